// File: rtl/bp_be_wb_arbiter.sv
// Writeback arbiter: merges two pipe completions and a queued long-latency
// result stream into at most two registered, collision-free regfile writes.
module bp_be_wb_arbiter #(
    parameter int data_width_p      = 64,
    parameter int reg_addr_width_gp = 5,
    parameter int tag_width_p       = 4,
    parameter int lq_els_p          = 4,
    parameter int zero_x0_p         = 1
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           flush_i,
    input  logic [1:0]                     pipe_v_i,
    input  logic [2*reg_addr_width_gp-1:0] pipe_addr_i,
    input  logic [2*data_width_p-1:0]      pipe_data_i,
    input  logic [2*tag_width_p-1:0]       pipe_tag_i,
    input  logic                           long_v_i,
    output logic                           long_ready_and_o,
    input  logic [reg_addr_width_gp-1:0]   long_addr_i,
    input  logic [data_width_p-1:0]        long_data_i,
    input  logic [tag_width_p-1:0]         long_tag_i,
    output logic [1:0]                     rd_w_v_o,
    output logic [2*reg_addr_width_gp-1:0] rd_addr_o,
    output logic [2*data_width_p-1:0]      rd_data_o,
    output logic [$clog2(lq_els_p+1)-1:0]  lq_count_o
);
    localparam int AW = reg_addr_width_gp;
    localparam int DW = data_width_p;
    localparam int TW = tag_width_p;
    localparam int PW = $clog2(lq_els_p);
    localparam int CW = $clog2(lq_els_p + 1);
    localparam logic ZX = (zero_x0_p != 0);

    // a is younger than b when (a - b) mod 2^TW lies in [1, 2^(TW-1))
    function automatic logic younger(input logic [TW-1:0] a, input logic [TW-1:0] b);
        logic [TW-1:0] d;
        logic [TW-1:0] half;
        d          = a - b;
        half       = '0;
        half[TW-1] = 1'b1;
        return (d != '0) && (d < half);
    endfunction

    logic [AW-1:0] lq_addr_q [lq_els_p];
    logic [DW-1:0] lq_data_q [lq_els_p];
    logic [TW-1:0] lq_tag_q  [lq_els_p];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [1:0]          rd_w_v_q;
    logic [2*AW-1:0]     rd_addr_q;
    logic [2*DW-1:0]     rd_data_q;

    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_data [2];
    logic [TW-1:0] p_tag  [2];
    logic [1:0]    p_v;

    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;
    logic [TW-1:0] h_tag;
    logic          head_ok, head_grant, enq, sel;

    logic [1:0]    iss_v;
    logic [AW-1:0] iss_addr [2];
    logic [DW-1:0] iss_data [2];

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            p_addr[i] = pipe_addr_i[i*AW +: AW];
            p_data[i] = pipe_data_i[i*DW +: DW];
            p_tag[i]  = pipe_tag_i[i*TW +: TW];
            p_v[i]    = pipe_v_i[i] & ~(ZX & (pipe_addr_i[i*AW +: AW] == '0));
        end
    end

    assign h_addr  = lq_addr_q[rptr_q];
    assign h_data  = lq_data_q[rptr_q];
    assign h_tag   = lq_tag_q[rptr_q];
    // A head that would be granted during a flush is simply never offered.
    assign head_ok = (count_q != '0) & ~flush_i;

    always_comb begin
        iss_v       = '0;
        iss_addr[0] = '0;
        iss_addr[1] = '0;
        iss_data[0] = '0;
        iss_data[1] = '0;
        head_grant  = 1'b0;
        sel         = 1'b0;
        if (p_v == 2'b11) begin
            if (p_addr[0] == p_addr[1]) begin
                sel         = ~younger(p_tag[0], p_tag[1]);
                iss_v       = 2'b01;
                iss_addr[0] = p_addr[sel];
                iss_data[0] = p_data[sel];
            end else begin
                iss_v       = 2'b11;
                iss_addr[0] = p_addr[0];
                iss_data[0] = p_data[0];
                iss_addr[1] = p_addr[1];
                iss_data[1] = p_data[1];
            end
        end else if (p_v != 2'b00) begin
            sel         = p_v[1];
            iss_v       = 2'b01;
            iss_addr[0] = p_addr[sel];
            iss_data[0] = p_data[sel];
            if (head_ok) begin
                head_grant = 1'b1;
                if (h_addr != p_addr[sel]) begin
                    iss_v       = 2'b11;
                    iss_addr[1] = h_addr;
                    iss_data[1] = h_data;
                end else if (younger(h_tag, p_tag[sel])) begin
                    iss_addr[0] = h_addr;
                    iss_data[0] = h_data;
                end
            end
        end else if (head_ok) begin
            head_grant  = 1'b1;
            iss_v       = 2'b01;
            iss_addr[0] = h_addr;
            iss_data[0] = h_data;
        end
    end

    assign long_ready_and_o = (count_q != CW'(lq_els_p));
    assign enq = long_v_i & long_ready_and_o & ~flush_i & ~(ZX & (long_addr_i == '0));

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq)        wptr_d = wptr_q + PW'(1);
            if (head_grant) rptr_d = rptr_q + PW'(1);
            count_d = count_q + CW'(enq) - CW'(head_grant);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            lq_addr_q[wptr_q] <= long_addr_i;
            lq_data_q[wptr_q] <= long_data_i;
            lq_tag_q[wptr_q]  <= long_tag_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rd_w_v_q  <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rd_w_v_q <= iss_v;
            for (int unsigned i = 0; i < 2; i++) begin
                if (iss_v[i]) begin
                    rd_addr_q[i*AW +: AW] <= iss_addr[i];
                    rd_data_q[i*DW +: DW] <= iss_data[i];
                end
            end
        end
    end

    assign rd_w_v_o   = rd_w_v_q;
    assign rd_addr_o  = rd_addr_q;
    assign rd_data_o  = rd_data_q;
    assign lq_count_o = count_q;

endmodule

// File: tb/tb_bp_be_wb_arbiter.sv
// Directed bench for bp_be_wb_arbiter: table of pipe-only vectors plus
// hand sequences for queue latency, fill/drain, collisions, flush and reset.
module tb_bp_be_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic [1:0]    pipe_v;
    logic [2*AW-1:0] pipe_addr;
    logic [2*DW-1:0] pipe_data;
    logic [2*TW-1:0] pipe_tag;
    logic          long_v;
    logic          long_ready;
    logic [AW-1:0] long_addr;
    logic [DW-1:0] long_data;
    logic [TW-1:0] long_tag;
    logic [1:0]    rd_w_v;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic [2:0]    lq_count;

    always #5 clk = ~clk;

    bp_be_wb_arbiter #(
        .data_width_p(DW), .reg_addr_width_gp(AW), .tag_width_p(TW),
        .lq_els_p(4), .zero_x0_p(1)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
        .pipe_v_i(pipe_v), .pipe_addr_i(pipe_addr), .pipe_data_i(pipe_data),
        .pipe_tag_i(pipe_tag), .long_v_i(long_v), .long_ready_and_o(long_ready),
        .long_addr_i(long_addr), .long_data_i(long_data), .long_tag_i(long_tag),
        .rd_w_v_o(rd_w_v), .rd_addr_o(rd_addr), .rd_data_o(rd_data),
        .lq_count_o(lq_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipes(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                             input logic [63:0] d0, input logic [63:0] d1,
                             input logic [3:0] t0, input logic [3:0] t1);
        pipe_v    = v;
        pipe_addr = {a1, a0};
        pipe_data = {d1, d0};
        pipe_tag  = {t1, t0};
    endtask

    task automatic set_long(input logic v, input logic [4:0] a, input logic [63:0] d, input logic [3:0] t);
        long_v    = v;
        long_addr = a;
        long_data = d;
        long_tag  = t;
    endtask

    task automatic chk_port(input string name, input int p, input logic [4:0] a, input logic [63:0] d);
        chk({name, "_addr"}, 64'(rd_addr[p*AW +: AW]), 64'(a));
        chk({name, "_data"}, rd_data[p*DW +: DW], d);
    endtask

    typedef struct {
        logic [1:0]  pv;
        logic [4:0]  a0, a1;
        logic [63:0] d0, d1;
        logic [3:0]  t0, t1;
        logic [1:0]  ev;
        logic [4:0]  ea0, ea1;
        logic [63:0] ed0, ed1;
    } vec_t;

    function automatic vec_t mk(logic [1:0] pv, logic [4:0] a0, logic [4:0] a1,
                                logic [63:0] d0, logic [63:0] d1, logic [3:0] t0, logic [3:0] t1,
                                logic [1:0] ev, logic [4:0] ea0, logic [63:0] ed0,
                                logic [4:0] ea1, logic [63:0] ed1);
        vec_t v;
        v.pv = pv; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.t0 = t0; v.t1 = t1;
        v.ev = ev; v.ea0 = ea0; v.ed0 = ed0; v.ea1 = ea1; v.ed1 = ed1;
        return v;
    endfunction

    vec_t vecs[12];

    initial begin
        vecs[0]  = mk(2'b11, 3, 7, 64'hA, 64'hB, 0, 1,    2'b11, 3, 64'hA, 7, 64'hB);
        vecs[1]  = mk(2'b11, 5, 5, 64'h1, 64'h2, 14, 1,   2'b01, 5, 64'h2, 0, 0);
        vecs[2]  = mk(2'b11, 5, 5, 64'h1, 64'h2, 1, 14,   2'b01, 5, 64'h1, 0, 0);
        vecs[3]  = mk(2'b01, 0, 0, 64'h55, 64'h0, 0, 0,   2'b00, 0, 0, 0, 0);
        vecs[4]  = mk(2'b10, 0, 4, 64'h0, 64'h44, 0, 0,   2'b01, 4, 64'h44, 0, 0);
        vecs[5]  = mk(2'b11, 0, 9, 64'h66, 64'h99, 0, 0,  2'b01, 9, 64'h99, 0, 0);
        vecs[6]  = mk(2'b00, 0, 0, 64'h0, 64'h0, 0, 0,    2'b00, 0, 0, 0, 0);
        vecs[7]  = mk(2'b11, 6, 6, 64'h61, 64'h62, 3, 2,  2'b01, 6, 64'h61, 0, 0);
        vecs[8]  = mk(2'b11, 8, 8, 64'h81, 64'h82, 0, 7,  2'b01, 8, 64'h82, 0, 0);
        vecs[9]  = mk(2'b11, 8, 8, 64'h81, 64'h82, 15, 8, 2'b01, 8, 64'h81, 0, 0);
        vecs[10] = mk(2'b11, 0, 0, 64'h1, 64'h2, 0, 0,    2'b00, 0, 0, 0, 0);
        vecs[11] = mk(2'b11, 30, 31, 64'hDEAD, 64'hBEEF, 4, 5, 2'b11, 30, 64'hDEAD, 31, 64'hBEEF);

        reset_n = 1'b0;
        flush   = 1'b0;
        set_pipes(2'b00, 0, 0, 0, 0, 0, 0);
        set_long(1'b0, 0, 0, 0);
        step();
        step();
        chk("rst_wv", 64'(rd_w_v), 0);
        chk("rst_addr", 64'(rd_addr), 0);
        chk("rst_data_lo", rd_data[63:0], 0);
        chk("rst_count", 64'(lq_count), 0);
        chk("rst_ready", 64'(long_ready), 1);
        @(negedge clk) reset_n = 1'b1;
        step();
        chk("idle_wv", 64'(rd_w_v), 0);

        for (int i = 0; i < 12; i++) begin
            set_pipes(vecs[i].pv, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1, vecs[i].t0, vecs[i].t1);
            step();
            chk($sformatf("vec%0d_wv", i), 64'(rd_w_v), 64'(vecs[i].ev));
            if (vecs[i].ev[0]) chk_port($sformatf("vec%0d_p0", i), 0, vecs[i].ea0, vecs[i].ed0);
            if (vecs[i].ev[1]) chk_port($sformatf("vec%0d_p1", i), 1, vecs[i].ea1, vecs[i].ed1);
        end
        set_pipes(2'b00, 0, 0, 0, 0, 0, 0);
        step();
        chk("hold_wv", 64'(rd_w_v), 0);
        chk_port("hold_p0", 0, 30, 64'hDEAD);
        chk_port("hold_p1", 1, 31, 64'hBEEF);

        // Long result: enqueued on first edge, written after the second.
        set_long(1'b1, 12, 64'h1200, 3);
        step();
        chk("lat_wv1", 64'(rd_w_v), 0);
        chk("lat_cnt1", 64'(lq_count), 1);
        set_long(1'b0, 0, 0, 0);
        step();
        chk("lat_wv2", 64'(rd_w_v), 1);
        chk_port("lat_p0", 0, 12, 64'h1200);
        chk("lat_cnt2", 64'(lq_count), 0);

        // Fill queue under dual-pipe traffic, then drain.
        set_pipes(2'b11, 1, 2, 64'h10, 64'h20, 0, 1);
        for (int k = 0; k < 4; k++) begin
            set_long(1'b1, 5'(10 + k), 64'h100 + 64'(k), 4'(k));
            step();
            chk($sformatf("fill_cnt%0d", k), 64'(lq_count), 64'(k + 1));
        end
        chk("fill_wv", 64'(rd_w_v), 3);
        chk("full_ready", 64'(long_ready), 0);
        set_long(1'b1, 14, 64'h104, 4);
        step();
        chk("held_cnt", 64'(lq_count), 4);
        chk("held_ready", 64'(long_ready), 0);
        set_long(1'b0, 0, 0, 0);
        set_pipes(2'b01, 20, 0, 64'h2000, 0, 9, 0);
        step();
        chk("drain0_wv", 64'(rd_w_v), 3);
        chk_port("drain0_p0", 0, 20, 64'h2000);
        chk_port("drain0_p1", 1, 10, 64'h100);
        chk("drain0_cnt", 64'(lq_count), 3);
        chk("drain0_ready", 64'(long_ready), 1);
        set_pipes(2'b00, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k < 4; k++) begin
            step();
            chk($sformatf("drain%0d_wv", k), 64'(rd_w_v), 1);
            chk_port($sformatf("drain%0d_p0", k), 0, 5'(10 + k), 64'h100 + 64'(k));
            chk($sformatf("drain%0d_cnt", k), 64'(lq_count), 64'(3 - k));
        end
        step();
        chk("drained_wv", 64'(rd_w_v), 0);

        // Queue head vs pipe0, same register: pipe younger.
        set_long(1'b1, 9, 64'h900, 2);
        step();
        chk("lcol_cnt", 64'(lq_count), 1);
        set_long(1'b0, 0, 0, 0);
        set_pipes(2'b01, 9, 0, 64'h33, 0, 3, 0);
        step();
        chk("lcol_wv", 64'(rd_w_v), 1);
        chk_port("lcol_p0", 0, 9, 64'h33);
        chk("lcol_cnt2", 64'(lq_count), 0);
        set_pipes(2'b00, 0, 0, 0, 0, 0, 0);
        step();
        chk("lcol_after_wv", 64'(rd_w_v), 0);

        // Queue head younger than pipe0.
        set_long(1'b1, 9, 64'h901, 3);
        step();
        set_long(1'b0, 0, 0, 0);
        set_pipes(2'b01, 9, 0, 64'h34, 0, 2, 0);
        step();
        chk("hcol_wv", 64'(rd_w_v), 1);
        chk_port("hcol_p0", 0, 9, 64'h901);
        chk("hcol_cnt", 64'(lq_count), 0);

        // Pipe1 alone plus queue head: compacted to ports 0 and 1.
        set_pipes(2'b00, 0, 0, 0, 0, 0, 0);
        set_long(1'b1, 17, 64'h1700, 5);
        step();
        set_long(1'b0, 0, 0, 0);
        set_pipes(2'b10, 0, 18, 0, 64'h1800, 0, 6);
        step();
        chk("p1h_wv", 64'(rd_w_v), 3);
        chk_port("p1h_p0", 0, 18, 64'h1800);
        chk_port("p1h_p1", 1, 17, 64'h1700);

        // Flush with two queued entries and an incoming long result.
        set_pipes(2'b11, 1, 2, 64'h10, 64'h20, 0, 1);
        set_long(1'b1, 21, 64'h2100, 1);
        step();
        set_long(1'b1, 22, 64'h2200, 2);
        step();
        chk("fl_pre_cnt", 64'(lq_count), 2);
        flush = 1'b1;
        set_long(1'b1, 23, 64'h2300, 3);
        set_pipes(2'b11, 3, 4, 64'h3, 64'h4, 4, 5);
        step();
        chk("fl_cnt", 64'(lq_count), 0);
        chk("fl_wv", 64'(rd_w_v), 3);
        chk_port("fl_p0", 0, 3, 64'h3);
        chk_port("fl_p1", 1, 4, 64'h4);
        flush = 1'b0;
        set_long(1'b0, 0, 0, 0);
        set_pipes(2'b00, 0, 0, 0, 0, 0, 0);
        step();
        chk("fl_post_wv", 64'(rd_w_v), 0);
        chk("fl_post_cnt", 64'(lq_count), 0);

        // Long result to x0 is accepted but never queued.
        set_long(1'b1, 0, 64'hABC, 0);
        chk("x0_ready", 64'(long_ready), 1);
        step();
        chk("x0_cnt", 64'(lq_count), 0);
        set_long(1'b0, 0, 0, 0);
        step();
        chk("x0_wv", 64'(rd_w_v), 0);

        // Asynchronous reset with three entries queued.
        set_pipes(2'b11, 1, 2, 64'h10, 64'h20, 0, 1);
        for (int k = 0; k < 3; k++) begin
            set_long(1'b1, 5'(24 + k), 64'h2400 + 64'(k), 4'(k));
            step();
        end
        chk("mr_pre_cnt", 64'(lq_count), 3);
        chk("mr_pre_wv", 64'(rd_w_v), 3);
        reset_n = 1'b0;
        #1;
        chk("mr_wv", 64'(rd_w_v), 0);
        chk("mr_cnt", 64'(lq_count), 0);
        chk("mr_ready", 64'(long_ready), 1);
        chk("mr_addr", 64'(rd_addr), 0);
        set_long(1'b0, 0, 0, 0);
        set_pipes(2'b00, 0, 0, 0, 0, 0, 0);
        @(negedge clk) reset_n = 1'b1;
        step();
        chk("mr_post_wv", 64'(rd_w_v), 0);
        step();
        chk("mr_post_wv2", 64'(rd_w_v), 0);
        chk("mr_post_cnt", 64'(lq_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
